// File: rtl/load_store_unit_if.sv
// CPU request/response and data-memory bus of the load/store unit.
// slave = the unit itself; master = the CPU plus the memory it drives.
interface load_store_unit_if #(
  parameter int N  = 32,
  parameter int DM = 7,
  parameter int AW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [N-1:0]  req_wdata;
  logic          resp_valid;
  logic [N-1:0]  resp_rdata;
  logic          misaligned;
  logic [DM-1:0] mem_addr;
  logic [N-1:0]  mem_wdata;
  logic          mem_read;
  logic          mem_write;
  logic [N-1:0]  mem_rdata;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, misaligned, mem_addr, mem_wdata, mem_read, mem_write
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, misaligned, mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store initiator for a registered-read word memory; sub-word stores use RMW.
// Latency error 1 / word store 2 / load 3 / sub-word store 4 cycles; req_ready only while idle.
module load_store_unit #(
  parameter int N  = 32,
  parameter int DM = 7,
  parameter int AW = 32
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ERR   = 3'd1;
  localparam logic [2:0] WR    = 3'd2;
  localparam logic [2:0] RD    = 3'd3;
  localparam logic [2:0] LWAIT = 3'd4;
  localparam logic [2:0] MERGE = 3'd5;
  localparam logic [2:0] RMWWR = 3'd6;
  localparam logic [2:0] RESP  = 3'd7;

  logic [2:0]    state;
  logic [DM+1:0] addr_q;
  logic [1:0]    size_q;
  logic          signed_q;
  logic          write_q;
  logic [N-1:0]  data_q;   // store data, becomes the merged word in MERGE
  logic [N-1:0]  rdata_q;

  logic          req_err;
  logic [4:0]    shamt;
  logic [N-1:0]  lane_mask;
  logic [N-1:0]  lane;
  logic [N-1:0]  merged;
  logic [N-1:0]  load_val;
  logic          mem_write_i;
  logic          unused_addr;

  assign unused_addr = ^bus.req_addr[AW-1:DM+2];

  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
      2'b01:   req_err = bus.req_addr[0];
      2'b10:   req_err = (bus.req_addr[1:0] != 2'b00);
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
  end

  // Lane position of the latched request; words always sit at lane 0.
  always_comb begin
    shamt     = 5'd0;
    lane_mask = '1;
    case (size_q)
      2'b00: begin
        shamt     = {addr_q[1:0], 3'b000};
        lane_mask = N'(32'h0000_00FF) << shamt;
      end
      2'b01: begin
        shamt     = {addr_q[1], 4'b0000};
        lane_mask = N'(32'h0000_FFFF) << shamt;
      end
      default: begin
        shamt     = 5'd0;
        lane_mask = '1;
      end
    endcase
  end

  assign lane   = bus.mem_rdata >> shamt;
  assign merged = (bus.mem_rdata & ~lane_mask) | ((data_q << shamt) & lane_mask);

  always_comb begin
    load_val = bus.mem_rdata;
    case (size_q)
      2'b00:   load_val = {{(N-8){signed_q & lane[7]}}, lane[7:0]};
      2'b01:   load_val = {{(N-16){signed_q & lane[15]}}, lane[15:0]};
      default: load_val = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      data_q   <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q   <= bus.req_addr[DM+1:0];
            size_q   <= bus.req_size;
            signed_q <= bus.req_signed;
            write_q  <= bus.req_write;
            data_q   <= bus.req_wdata;
            rdata_q  <= '0;
            if (req_err)
              state <= ERR;
            else if (bus.req_write && bus.req_size == 2'b10)
              state <= WR;
            else
              state <= RD;
          end
        end
        ERR:   state <= IDLE;
        WR:    state <= RESP;
        RD:    state <= write_q ? MERGE : LWAIT;
        LWAIT: begin
          rdata_q <= load_val;
          state   <= RESP;
        end
        MERGE: begin
          data_q <= merged;
          state  <= RMWWR;
        end
        RMWWR: state <= RESP;
        RESP:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_write_i    = (state == WR) || (state == RMWWR);
  assign bus.req_ready  = (state == IDLE);
  assign bus.mem_read   = (state == RD);
  assign bus.mem_write  = mem_write_i;
  assign bus.mem_addr   = addr_q[DM+1:2];
  assign bus.mem_wdata  = mem_write_i ? data_q : '0;
  assign bus.resp_valid = (state == ERR) || (state == RESP);
  assign bus.misaligned = (state == ERR);
  assign bus.resp_rdata = (state == RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized traffic against a byte-level model.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_store_unit_if #(.N(32), .DM(7), .AW(32)) bus ();
  load_store_unit #(.N(32), .DM(7), .AW(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Data memory: registered read, write on the edge.
  logic [31:0] mem [0:127];
  logic [31:0] rd_q;
  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_read)  rd_q <= mem[bus.mem_addr];
  end
  assign bus.mem_rdata = rd_q;

  int errors = 0;
  int checks = 0;
  logic [31:0] ref_mem [0:127];

  function automatic bit ref_err(input int size, input int a);
    return (size == 3) || (size == 1 && (a % 2) != 0) || (size == 2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input int size, input bit sgn, input int a);
    longint v;
    if (size == 2) return w;
    if (size == 0) begin
      v = longint'((w >> (8 * (a % 4))) % 256);
      if (sgn && v >= 128) v = v - 256;
    end else begin
      v = longint'((w >> (16 * ((a % 4) / 2))) % 65536);
      if (sgn && v >= 32768) v = v - 65536;
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input int size, input int a, input logic [31:0] d);
    logic [7:0] by [4];
    int b;
    if (size == 2) return d;
    for (int i = 0; i < 4; i++) by[i] = 8'(w >> (8 * i));
    b = a % 4;
    if (size == 0) by[b] = d[7:0];
    else begin
      by[b - (b % 2)]     = d[7:0];
      by[b - (b % 2) + 1] = d[15:8];
    end
    return {by[3], by[2], by[1], by[0]};
  endfunction

  function automatic int ref_lat(input bit wr, input int size, input int a);
    if (ref_err(size, a)) return 1;
    if (wr && size == 2) return 2;
    if (!wr) return 3;
    return 4;
  endfunction

  // Issues one request and observes it until its response (bounded).
  task automatic do_req(input bit wr, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rdata,
                        output logic mis, output int nrd, output int nwr, output int rdc,
                        output int wrc, output logic [31:0] wdat, output int bad);
    int guard;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
    bus.req_signed = sg;  bus.req_addr = a;   bus.req_wdata = d;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = -1; rdata = '0; mis = 1'b0; nrd = 0; nwr = 0; rdc = 0; wrc = 0; wdat = '0; bad = 0;
    for (int k = 1; k <= 12 && lat < 0; k++) begin
      @(negedge clk);
      if (bus.mem_read && bus.mem_write) bad++;
      if (bus.misaligned && !bus.resp_valid) bad++;
      if ((bus.mem_read || bus.mem_write) && bus.mem_addr != a[8:2]) bad++;
      if (bus.mem_read) begin nrd++; rdc = k; end
      if (bus.mem_write) begin nwr++; wrc = k; wdat = bus.mem_wdata; end
      if (bus.resp_valid) begin lat = k; rdata = bus.resp_rdata; mis = bus.misaligned; end
    end
    @(negedge clk);
    if (bus.resp_valid || bus.resp_rdata != 0 || bus.misaligned || bus.mem_read || bus.mem_write) bad++;
  endtask

  int lat, nrd, nwr, rdc, wrc, bad;
  logic [31:0] rdata, wdat;
  logic mis;

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b need 1", bus.req_ready);
    end
    checks++;
    if ({bus.resp_valid, bus.misaligned, bus.mem_read, bus.mem_write, bus.resp_rdata, bus.mem_wdata, bus.mem_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rv=%b mis=%b rd=%b wr=%b rdata=%h wdata=%h addr=%h need all 0",
               bus.resp_valid, bus.misaligned, bus.mem_read, bus.mem_write, bus.resp_rdata, bus.mem_wdata, bus.mem_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_word();
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rdata, mis, nrd, nwr, rdc, wrc, wdat, bad);
    ref_mem[4] = 32'hDEADBEEF;
    checks++;
    if (lat !== 2 || nrd !== 0 || nwr !== 1 || wrc !== 1 || wdat !== 32'hDEADBEEF || bad !== 0 || mis !== 1'b0) begin
      errors++;
      $display("FAIL word_store: lat=%0d rd=%0d wr=%0d wrc=%0d wdata=%h bad=%0d mis=%b need lat=2 rd=0 wr=1 wrc=1 wdata=deadbeef bad=0 mis=0",
               lat, nrd, nwr, wrc, wdat, bad, mis);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rdata, mis, nrd, nwr, rdc, wrc, wdat, bad);
    checks++;
    if (lat !== 3 || rdata !== 32'hDEADBEEF || nrd !== 1 || rdc !== 1 || nwr !== 0 || bad !== 0) begin
      errors++;
      $display("FAIL word_load: lat=%0d rdata=%h rd=%0d rdc=%0d wr=%0d bad=%0d need lat=3 rdata=deadbeef rd=1 rdc=1 wr=0 bad=0",
               lat, rdata, nrd, rdc, nwr, bad);
    end
  endtask

  task automatic test_rmw_store();
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, lat, rdata, mis, nrd, nwr, rdc, wrc, wdat, bad);
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FFA5, lat, rdata, mis, nrd, nwr, rdc, wrc, wdat, bad);
    ref_mem[4] = 32'h1122A544;
    checks++;
    if (lat !== 4 || nrd !== 1 || rdc !== 1 || nwr !== 1 || wrc !== 3 || wdat !== 32'h1122A544 || bad !== 0 || rdata !== 0) begin
      errors++;
      $display("FAIL byte_rmw: lat=%0d rd=%0d@%0d wr=%0d@%0d wdata=%h bad=%0d rdata=%h need lat=4 rd=1@1 wr=1@3 wdata=1122a544 bad=0 rdata=0",
               lat, nrd, rdc, nwr, wrc, wdat, bad, rdata);
    end
    checks++;
    if (mem[4] !== 32'h1122A544) begin
      errors++; $display("FAIL byte_rmw_mem: got %h need 1122a544", mem[4]);
    end
  endtask

  task automatic test_load_ext();
    logic [31:0] exp_v [4] = '{32'hFFFFFFA5, 32'h000000A5, 32'hFFFF8001, 32'h00008001};
    logic [1:0]  szs   [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic [31:0] adr   [4] = '{32'h11, 32'h11, 32'h12, 32'h12};
    bit          sgs   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h8001A544, lat, rdata, mis, nrd, nwr, rdc, wrc, wdat, bad);
    ref_mem[4] = 32'h8001A544;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, szs[i], sgs[i], adr[i], 32'h0, lat, rdata, mis, nrd, nwr, rdc, wrc, wdat, bad);
      checks++;
      if (lat !== 3 || rdata !== exp_v[i] || mis !== 1'b0 || nwr !== 0 || bad !== 0) begin
        errors++;
        $display("FAIL load_ext[%0d]: lat=%0d rdata=%h mis=%b wr=%0d bad=%0d need lat=3 rdata=%h mis=0 wr=0 bad=0",
                 i, lat, rdata, mis, nwr, bad, exp_v[i]);
      end
    end
  endtask

  task automatic test_errors();
    bit          wrs [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  szs [3] = '{2'b01, 2'b10, 2'b11};
    logic [31:0] adr [3] = '{32'h13, 32'h12, 32'h10};
    for (int i = 0; i < 3; i++) begin
      do_req(wrs[i], szs[i], 1'b1, adr[i], 32'hCAFEF00D, lat, rdata, mis, nrd, nwr, rdc, wrc, wdat, bad);
      checks++;
      if (lat !== 1 || mis !== 1'b1 || rdata !== 0 || nrd !== 0 || nwr !== 0 || bad !== 0) begin
        errors++;
        $display("FAIL error_req[%0d]: lat=%0d mis=%b rdata=%h rd=%0d wr=%0d bad=%0d need lat=1 mis=1 rdata=0 rd=0 wr=0 bad=0",
                 i, lat, mis, rdata, nrd, nwr, bad);
      end
    end
    checks++;
    if (mem[4] !== ref_mem[4]) begin
      errors++; $display("FAIL error_mem: got %h need %h", mem[4], ref_mem[4]);
    end
  endtask

  task automatic test_reset_mid();
    int wr_seen = 0;
    int resp_seen = 0;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, lat, rdata, mis, nrd, nwr, rdc, wrc, wdat, bad);
    ref_mem[4] = 32'h11223344;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b01;
    bus.req_addr = 32'h12; bus.req_wdata = 32'h0000BEEF;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    if (bus.mem_write) wr_seen++;
    @(negedge clk);
    if (bus.mem_write) wr_seen++;
    reset = 1'b1;
    @(negedge clk);
    if (bus.mem_write) wr_seen++;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.mem_read !== 1'b0 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_state: ready=%b rd=%b rv=%b need ready=1 rd=0 rv=0", bus.req_ready, bus.mem_read, bus.resp_valid);
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.mem_write) wr_seen++;
      if (bus.resp_valid) resp_seen++;
    end
    checks++;
    if (wr_seen !== 0 || resp_seen !== 0 || mem[4] !== 32'h11223344) begin
      errors++;
      $display("FAIL reset_mid_abort: writes=%0d resps=%0d mem=%h need writes=0 resps=0 mem=11223344", wr_seen, resp_seen, mem[4]);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rdata, mis, nrd, nwr, rdc, wrc, wdat, bad);
    checks++;
    if (lat !== 3 || rdata !== 32'h11223344) begin
      errors++; $display("FAIL reset_mid_reload: lat=%0d rdata=%h need lat=3 rdata=11223344", lat, rdata);
    end
  endtask

  task automatic test_random();
    bit wr, sg;
    logic [1:0] sz;
    logic [31:0] a, d, exp_rd, exp_w;
    int exp_lat, mism;
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      do_req(1'b1, 2'b10, 1'b0, 32'(w * 4), d, lat, rdata, mis, nrd, nwr, rdc, wrc, wdat, bad);
      ref_mem[w] = d;
    end
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3)); a = 32'($urandom_range(0, 63)); d = $urandom;
      exp_lat = ref_lat(wr, int'(sz), int'(a));
      exp_rd  = (!wr && !ref_err(int'(sz), int'(a))) ? ref_load(ref_mem[a / 4], int'(sz), sg, int'(a)) : 32'h0;
      exp_w   = ref_store(ref_mem[a / 4], int'(sz), int'(a), d);
      do_req(wr, sz, sg, a, d, lat, rdata, mis, nrd, nwr, rdc, wrc, wdat, bad);
      checks++;
      if (lat !== exp_lat || rdata !== exp_rd || mis !== ref_err(int'(sz), int'(a)) || bad !== 0) begin
        errors++;
        $display("FAIL rand[%0d] wr=%b sz=%0d a=%h: lat=%0d rdata=%h mis=%b bad=%0d need lat=%0d rdata=%h mis=%b bad=0",
                 i, wr, sz, a, lat, rdata, mis, bad, exp_lat, exp_rd, ref_err(int'(sz), int'(a)));
      end
      if (wr && !ref_err(int'(sz), int'(a))) begin
        ref_mem[a / 4] = exp_w;
        checks++;
        if (nwr !== 1 || wdat !== exp_w) begin
          errors++; $display("FAIL rand_store[%0d]: writes=%0d wdata=%h need writes=1 wdata=%h", i, nwr, wdat, exp_w);
        end
      end
    end
    mism = 0;
    for (int w = 0; w < 16; w++) if (mem[w] !== ref_mem[w]) mism++;
    checks++;
    if (mism !== 0) begin
      errors++; $display("FAIL rand_mem: %0d words differ, need 0", mism);
    end
  endtask

  task automatic test_back_to_back();
    localparam int NB = 12;
    bit          wrs [NB];
    logic [1:0]  szs [NB];
    bit          sgs [NB];
    logic [31:0] ads [NB];
    logic [31:0] dts [NB];
    logic [32:0] expq [$];
    logic [32:0] obsq [$];
    int idx = 0;
    bit acc;
    for (int i = 0; i < NB; i++) begin
      wrs[i] = 1'($urandom_range(0, 1)); sgs[i] = 1'($urandom_range(0, 1));
      szs[i] = 2'($urandom_range(0, 3)); ads[i] = 32'($urandom_range(0, 63)); dts[i] = $urandom;
      if (ref_err(int'(szs[i]), int'(ads[i]))) expq.push_back({1'b1, 32'h0});
      else if (wrs[i]) begin
        ref_mem[ads[i] / 4] = ref_store(ref_mem[ads[i] / 4], int'(szs[i]), int'(ads[i]), dts[i]);
        expq.push_back({1'b0, 32'h0});
      end else expq.push_back({1'b0, ref_load(ref_mem[ads[i] / 4], int'(szs[i]), sgs[i], int'(ads[i]))});
    end
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = wrs[0]; bus.req_size = szs[0];
    bus.req_signed = sgs[0]; bus.req_addr = ads[0]; bus.req_wdata = dts[0];
    for (int c = 0; c < 300 && obsq.size() < NB; c++) begin
      if (bus.resp_valid) obsq.push_back({bus.misaligned, bus.resp_rdata});
      acc = bus.req_ready && idx < NB;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < NB) begin
          bus.req_write = wrs[idx]; bus.req_size = szs[idx]; bus.req_signed = sgs[idx];
          bus.req_addr = ads[idx]; bus.req_wdata = dts[idx];
        end else bus.req_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    checks++;
    if (obsq.size() !== NB || idx !== NB) begin
      errors++; $display("FAIL b2b_count: responses=%0d accepts=%0d need %0d", obsq.size(), idx, NB);
    end
    for (int i = 0; i < NB && i < obsq.size(); i++) begin
      checks++;
      if (obsq[i] !== expq[i]) begin
        errors++; $display("FAIL b2b_resp[%0d]: got mis/data=%h need %h", i, obsq[i], expq[i]);
      end
    end
    repeat (3) @(negedge clk);
    for (int w = 0; w < 16; w++) begin
      if (mem[w] !== ref_mem[w]) begin
        checks++; errors++;
        $display("FAIL b2b_mem[%0d]: got %h need %h", w, mem[w], ref_mem[w]);
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    reset = 1'b1;
    test_reset();
    test_word();
    test_rmw_store();
    test_load_ext();
    test_errors();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
